delay_var_bus: RTL and testbench



---
 rtl/delay_var_bus_if.sv | 24 ++
 rtl/delay_var_bus.sv | 89 ++++++++
 tb/tb_delay_var_bus.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/delay_var_bus_if.sv
// Sample-stream bus of the programmable delay line: input sample, strobe,
// requested delay, and the delayed sample with its validity flag.
interface delay_var_bus_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
);
  logic [WIDTH-1:0] d;
  logic             d_stb;
  logic [AW:0]      dly;
  logic [WIDTH-1:0] q;
  logic             q_valid;

  // Producer side: drives samples and the requested delay.
  modport master (
    output d, d_stb, dly,
    input  q, q_valid
  );

  // Delay line side.
  modport slave (
    input  d, d_stb, dly,
    output q, q_valid
  );
endinterface

// File: rtl/delay_var_bus.sv
// Runtime-programmable bus delay line on a 2^AW-deep circular buffer.
// Every strobe writes d at the write pointer and loads q with the sample of
// the D-th most recent strobe (the current one counts as the 1st), so with a
// continuous strobe this is a plain D-cycle delay with no extra latency.
module delay_var_bus #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
) (
  input  logic         clk,
  input  logic         rst,
  delay_var_bus_if.slave bus
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_V   = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_q,    wr_d;
  logic [AW:0]      fill_q,  fill_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             valid_q, valid_d;

  logic [AW:0]      dly_eff;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [AW+1:0]    fill_inc;

  // Clamp the requested delay into 1..DEPTH and fetch the D-th most recent slot.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    dly_eff = bus.dly;
    if (bus.dly == '0) begin
      dly_eff = ONE_V;
    end else if (bus.dly > DEPTH_V) begin
      dly_eff = DEPTH_V;
    end
    // The current sample sits at wr_q, so the D-th most recent is D-1 slots back.
    // For D = DEPTH this lands on wr_q+1, the oldest surviving sample.
    rd_addr = wr_q - AW'(dly_eff - ONE_V);
    rd_data = mem[rd_addr];
  end

  // Next state: advance pointer, fill counter and output only on a strobe.
  always_comb begin
    wr_d     = wr_q;
    fill_d   = fill_q;
    q_d      = q_q;
    valid_d  = valid_q;
    fill_inc = {1'b0, fill_q} + {1'b0, ONE_V};
    if (bus.d_stb) begin
      wr_d    = wr_q + AW'(1);
      fill_d  = (fill_q == DEPTH_V) ? fill_q : fill_inc[AW:0];
      valid_d = (fill_inc >= {1'b0, dly_eff});
      // D = 1 is the sample arriving now; it is not in the memory yet, so bypass.
      q_d     = (dly_eff == ONE_V) ? bus.d : rd_data;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      fill_q  <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep all registers sampling pre-edge values.
      wr_q    <= wr_d;
      fill_q  <= fill_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  // Sample storage; a strobe coincident with reset is discarded.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is deliberately not reset; q_valid masks stale contents,
    // and leaving it unreset lets it map onto RAM primitives.
    if (!rst && bus.d_stb) begin
      mem[wr_q] <= bus.d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_valid = valid_q;

endmodule

// File: tb/tb_delay_var_bus.sv
// Directed bench for delay_var_bus: ramp streams at several delays, sparse
// strobes, clamping, mid-stream delay changes and reset during a stream.
module tb_delay_var_bus;

  localparam int WIDTH = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  delay_var_bus_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  delay_var_bus #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Strobed samples since the last reset, oldest first.
  logic [7:0] hist [0:1023];
  int         n;
  logic       exp_v;
  logic [7:0] exp_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_d(input int dl);
    if (dl == 0) return 1;
    if (dl > DEPTH) return DEPTH;
    return dl;
  endfunction

  // One clock with the given inputs; outputs are checked 1 ns after the edge.
  task automatic cyc(input logic [7:0] dv, input logic stb, input logic [6:0] dl);
    int dd;
    bus.d     = dv;
    bus.d_stb = stb;
    bus.dly   = dl;
    @(posedge clk);
    #1;
    if (stb) begin
      hist[n] = dv;
      n++;
      dd    = clamp_d(int'(dl));
      exp_v = (n >= dd);
      if (exp_v) exp_q = hist[n - dd];
    end
    check("q_valid", {31'd0, bus.q_valid}, {31'd0, exp_v});
    if (exp_v) check("q", {24'd0, bus.q}, {24'd0, exp_q});
  endtask

  // Reset for one edge with a concurrent strobe that must be discarded.
  task automatic do_reset();
    bus.d     = 8'hEE;
    bus.d_stb = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    n     = 0;
    exp_v = 1'b0;
    exp_q = 8'h00;
    check("reset_q", {24'd0, bus.q}, 32'h0);
    check("reset_valid", {31'd0, bus.q_valid}, 32'h0);
    bus.d_stb = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.d     = '0;
    bus.d_stb = 1'b0;
    bus.dly   = 7'd1;
    n         = 0;
    exp_v     = 1'b0;
    exp_q     = '0;
    @(posedge clk);
    #1;
    do_reset();

    // D = 1: q follows d one cycle later, valid from the first strobe.
    for (int i = 0; i < 10; i++) cyc(8'(i), 1'b1, 7'd1);
    check("d1_last_q", {24'd0, bus.q}, 32'd9);

    // D = 5 ramp from 0x10: valid rises at the 5th strobe with q = 0x10.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(8'h10 + 8'(i), 1'b1, 7'd5);
      if (i == 3) check("d5_not_yet_valid", {31'd0, bus.q_valid}, 32'd0);
      if (i == 4) check("d5_first_q", {24'd0, bus.q}, 32'h10);
    end
    check("d5_last_q", {24'd0, bus.q}, 32'h10 + 32'd10);

    // D = 5 with sparse strobes: q only moves on strobe cycles.
    do_reset();
    for (int i = 0; i < 30; i++) cyc(8'h80 + 8'(i), (i % 3) == 0, 7'd5);
    // Strobes at i = 0,3,...,27 -> 10th strobe carries 0x9B; 5 back is i=15.
    check("sparse_last_q", {24'd0, bus.q}, 32'h8F);

    // Full depth, then an over-range request that clamps to 64.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      cyc(8'(i), 1'b1, (i < 100) ? 7'd64 : 7'd100);
      if (i == 62) check("d64_not_yet_valid", {31'd0, bus.q_valid}, 32'd0);
      if (i == 63) check("d64_first_q", {24'd0, bus.q}, 32'd0);
    end
    check("d64_wrap_q", {24'd0, bus.q}, 32'd136);

    // Mid-stream delay changes: 8 -> 3 at strobe 40, -> 12 at 50, -> 0 at 60.
    do_reset();
    for (int k = 1; k <= 65; k++) begin
      cyc(8'(k), 1'b1, (k < 40) ? 7'd8 : (k < 50) ? 7'd3 : (k < 60) ? 7'd12 : 7'd0);
      if (k == 40) check("shrink_q", {24'd0, bus.q}, 32'd38);
      if (k == 50) begin
        check("grow_q", {24'd0, bus.q}, 32'd39);
        check("grow_valid", {31'd0, bus.q_valid}, 32'd1);
      end
      if (k == 60) check("dly0_q", {24'd0, bus.q}, 32'd60);
    end

    // D = 4 stream interrupted by reset on the 30th strobe.
    do_reset();
    for (int k = 1; k <= 29; k++) cyc(8'h40 + 8'(k), 1'b1, 7'd4);
    do_reset();
    for (int j = 0; j < 8; j++) begin
      cyc(8'hA0 + 8'(j), 1'b1, 7'd4);
      if (j == 2) check("post_reset_not_valid", {31'd0, bus.q_valid}, 32'd0);
      if (j == 3) check("post_reset_first_q", {24'd0, bus.q}, 32'hA0);
    end

    // Idle cycles hold the output.
    for (int i = 0; i < 3; i++) cyc(8'h55, 1'b0, 7'd1);
    check("idle_hold_q", {24'd0, bus.q}, 32'hA4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
